// File: rtl/interlock_pkg.sv
// Shared constants and channel numbering for the 8x8 interlock output monitor.
package interlock_pkg;

  localparam int unsigned N_PCH = 8;
  localparam int unsigned N_CH  = 28;
  localparam int unsigned N_TOT = N_PCH + N_CH;

  typedef logic [5:0] ch_idx_t;

  typedef enum logic {
    BANK_P = 1'b0,
    BANK_O = 1'b1
  } bank_t;

  // Power bank maps to 1..8, output bank to 9..36.
  function automatic ch_idx_t ch_num(bank_t bank, int unsigned idx);
    return (bank == BANK_P) ? ch_idx_t'(idx) : ch_idx_t'(N_PCH + idx);
  endfunction

endpackage

// File: rtl/rb_channel.sv
// One readback channel: synchronizer, matched command delay, persistent-mismatch
// counter and the latched fault bit with set-over-clear priority.
module rb_channel #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MISMATCH_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd,
  input  logic fb,
  input  logic clr_fault,
  output logic fault,
  output logic fault_nxt,
  output logic set
);

  localparam int unsigned CW = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MISMATCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] fb_q;
  logic [SYNC_STAGES-1:0] cmd_q;
  logic [CW-1:0]          cnt;
  logic                   mis;
  logic                   clr_ok;

  assign mis       = cmd_q[SYNC_STAGES-1] ^ fb_q[SYNC_STAGES-1];
  assign set       = mis && (cnt == CNT_MAX);
  // Only a channel that is quiet and has a zeroed counter may be cleared.
  assign clr_ok    = clr_fault && !mis && (cnt == '0);
  assign fault_nxt = set | (fault & ~clr_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q  <= '0;
      cmd_q <= '0;
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      fb_q  <= {fb_q[SYNC_STAGES-2:0], fb};
      cmd_q <= {cmd_q[SYNC_STAGES-2:0], cmd};
      if (!mis)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      fault <= fault_nxt;
    end
  end

endmodule

// File: rtl/out_readback_monitor.sv
// Output readback monitor: 36 readback channels, first-fault encoder and the
// registered any_fault/kill shutdown outputs.
module out_readback_monitor
  import interlock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MISMATCH_CYCLES = 1000
) (
  input  logic         pclk_50M,
  input  logic         rst,
  input  logic [1:8]   eoutP,
  input  logic [1:28]  eout,
  input  logic [1:8]   fbP,
  input  logic [1:28]  fb,
  input  logic         clr_fault,
  output logic [1:8]   faultP,
  output logic [1:28]  fault,
  output logic         any_fault,
  output logic         kill,
  output logic [5:0]   first_ch
);

  logic [1:N_TOT] fault_all;
  logic [1:N_TOT] nxt_all;
  logic [1:N_TOT] set_all;
  ch_idx_t        enc;
  logic           nxt_any;

  for (genvar p = 1; p <= N_PCH; p++) begin : g_pch
    localparam int unsigned CH = int'(ch_num(BANK_P, p));
    rb_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .MISMATCH_CYCLES(MISMATCH_CYCLES)
    ) u_ch (
      .clk      (pclk_50M),
      .rst      (rst),
      .cmd      (eoutP[p]),
      .fb       (fbP[p]),
      .clr_fault(clr_fault),
      .fault    (fault_all[CH]),
      .fault_nxt(nxt_all[CH]),
      .set      (set_all[CH])
    );
  end

  for (genvar j = 1; j <= N_CH; j++) begin : g_ch
    localparam int unsigned CH = int'(ch_num(BANK_O, j));
    rb_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .MISMATCH_CYCLES(MISMATCH_CYCLES)
    ) u_ch (
      .clk      (pclk_50M),
      .rst      (rst),
      .cmd      (eout[j]),
      .fb       (fb[j]),
      .clr_fault(clr_fault),
      .fault    (fault_all[CH]),
      .fault_nxt(nxt_all[CH]),
      .set      (set_all[CH])
    );
  end

  assign faultP  = fault_all[1:N_PCH];
  assign fault   = fault_all[N_PCH+1:N_TOT];
  assign nxt_any = |nxt_all;

  always_comb begin
    enc = '0;
    for (int unsigned k = 1; k <= N_TOT; k++) begin
      if (set_all[k] && (enc == '0))
        enc = ch_idx_t'(k);
    end
  end

  always_ff @(posedge pclk_50M or posedge rst) begin
    if (rst) begin
      any_fault <= 1'b0;
      kill      <= 1'b0;
      first_ch  <= '0;
    end else begin
      any_fault <= nxt_any;
      kill      <= nxt_any;
      if (!nxt_any)
        first_ch <= '0;
      else if ((first_ch == '0) && (|set_all))
        first_ch <= enc;
    end
  end

endmodule

// File: tb/tb_out_readback_monitor.sv
// Directed self-checking bench for out_readback_monitor (MISMATCH_CYCLES=8).
module tb_out_readback_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:8]  eoutP = '0;
  logic [1:28] eout = '0;
  logic [1:8]  fbP = '0;
  logic [1:28] fb = '0;
  logic        clr_fault = 1'b0;
  logic [1:8]  faultP;
  logic [1:28] fault;
  logic        any_fault;
  logic        kill;
  logic [5:0]  first_ch;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [1:8]  exp_p;
  logic [1:28] exp_o;

  always #10 clk = ~clk;

  out_readback_monitor #(
    .SYNC_STAGES    (2),
    .MISMATCH_CYCLES(8)
  ) dut (
    .pclk_50M (clk),
    .rst      (rst),
    .eoutP    (eoutP),
    .eout     (eout),
    .fbP      (fbP),
    .fb       (fb),
    .clr_fault(clr_fault),
    .faultP   (faultP),
    .fault    (fault),
    .any_fault(any_fault),
    .kill     (kill),
    .first_ch (first_ch)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:8] ep, input logic [1:28] eo,
                           input logic [5:0] efirst, input logic ekill);
    check({tag, ".faultP"},    64'(faultP),    64'(ep));
    check({tag, ".fault"},     64'(fault),     64'(eo));
    check({tag, ".first_ch"},  64'(first_ch),  64'(efirst));
    check({tag, ".kill"},      64'(kill),      64'(ekill));
    check({tag, ".any_fault"}, 64'(any_fault), 64'(ekill));
  endtask

  task automatic clr_pulse;
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
  endtask

  initial begin
    // Reset values
    #35;
    check_all("reset", '0, '0, 6'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Matched pattern held 200 cycles
    eoutP = 8'b11110101; fbP = 8'b11110101;
    eout  = 28'h0FF0068; fb  = 28'h0FF0068;
    tick(200);
    check_all("matched", '0, '0, 6'd0, 1'b0);

    // 1-cycle glitch on fb[16]
    fb[16] = ~fb[16]; tick(1); fb[16] = eout[16]; tick(20);
    check_all("glitch1", '0, '0, 6'd0, 1'b0);

    // 7-cycle glitch on fb[16]
    fb[16] = ~fb[16]; tick(7); fb[16] = eout[16]; tick(20);
    check_all("glitch7", '0, '0, 6'd0, 1'b0);

    // Persistent mismatch on channel 3: fault exactly at edge 10
    fbP[3] = ~eoutP[3];
    tick(9);
    check_all("ch3_edge9", '0, '0, 6'd0, 1'b0);
    tick(1);
    exp_p = '0; exp_p[3] = 1'b1; exp_o = '0;
    check_all("ch3_edge10", exp_p, exp_o, 6'd3, 1'b1);
    fbP[3] = eoutP[3]; tick(20);
    check_all("ch3_sticky", exp_p, exp_o, 6'd3, 1'b1);
    clr_pulse();
    check_all("ch3_clear", '0, '0, 6'd0, 1'b0);

    // Channels 5 and 20 together
    fbP[5] = ~eoutP[5]; fb[12] = ~eout[12];
    tick(10);
    exp_p = '0; exp_p[5] = 1'b1; exp_o = '0; exp_o[12] = 1'b1;
    check_all("ch5_20_set", exp_p, exp_o, 6'd5, 1'b1);
    fbP[5] = eoutP[5]; tick(3);
    clr_pulse();
    exp_p = '0;
    check_all("ch5_cleared", exp_p, exp_o, 6'd5, 1'b1);
    fb[12] = eout[12]; tick(3);
    clr_pulse();
    check_all("ch20_cleared", '0, '0, 6'd0, 1'b0);

    // Clear on the same edge a fault sets: set wins
    fbP[1] = ~eoutP[1];
    tick(9);
    clr_pulse();
    exp_p = '0; exp_p[1] = 1'b1;
    check_all("set_vs_clr", exp_p, '0, 6'd1, 1'b1);
    fbP[1] = eoutP[1]; tick(3);
    clr_pulse();
    check_all("ch1_cleared", '0, '0, 6'd0, 1'b0);

    // Latch a fault on channel 36, then start a count on channel 2 and reset mid-count
    fb[28] = ~eout[28];
    tick(10);
    exp_o = '0; exp_o[28] = 1'b1;
    check_all("ch36_set", '0, exp_o, 6'd36, 1'b1);
    fbP[2] = ~eoutP[2];
    tick(5);
    rst = 1'b1; #1;
    check_all("async_rst", '0, '0, 6'd0, 1'b0);
    fb[28] = eout[28];
    tick(2);
    rst = 1'b0;

    // Re-mismatch after release needs the full 10 edges
    tick(9);
    check_all("post_rst_edge9", '0, '0, 6'd0, 1'b0);
    tick(1);
    exp_p = '0; exp_p[2] = 1'b1;
    check_all("post_rst_edge10", exp_p, '0, 6'd2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
